// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a zeroing sweep after reset / init_start.
// Optional RF_ARB_R0_PROTECT_EN: writes to register 0 are accepted but never reach the register file.
module regfile_write_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic                         init_start,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         rf_write,
  output logic [ADDR_W-1:0]            rf_write_reg,
  output logic [DATA_W-1:0]            rf_write_data
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned SUM_W = ID_W + 1;

`ifdef RF_ARB_R0_PROTECT_EN
  localparam bit R0_PROTECT = 1'b1;
`else
  localparam bit R0_PROTECT = 1'b0;
`endif

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   cnt, cnt_d;
  logic [ID_W-1:0]     ptr, ptr_d;
  logic                busy_d;
  logic [ID_W-1:0]     gid_d;
  logic                wr_d;
  logic [ADDR_W-1:0]   reg_d;
  logic [DATA_W-1:0]   data_d;

  logic                gnt_any;
  logic [ID_W-1:0]     gnt_idx;
  logic [SUM_W-1:0]    scan_sum;

  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Rotating priority search starting at ptr; no grant while sweeping or restarting
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    scan_sum  = '0;
    if (state == S_RUN && !init_start) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        scan_sum = {1'b0, ptr} + SUM_W'(off);
        if (scan_sum >= SUM_W'(NUM_REQ)) scan_sum = scan_sum - SUM_W'(NUM_REQ);
        if (!gnt_any && req_valid[scan_sum[ID_W-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_sum[ID_W-1:0];
        end
      end
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end
  end

  // Next state, sweep counter, pointer and registered write-port values
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ptr_d   = ptr;
    gid_d   = grant_id;
    wr_d    = 1'b0;
    reg_d   = rf_write_reg;
    data_d  = rf_write_data;
    case (state)
      S_INIT: begin
        wr_d   = !(R0_PROTECT && cnt == '0);
        reg_d  = cnt;
        data_d = '0;
        cnt_d  = cnt + ADDR_W'(1);
        if (cnt == {ADDR_W{1'b1}}) state_d = S_RUN;
      end
      S_RUN: begin
        if (init_start) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end else if (gnt_any) begin
          wr_d   = !(R0_PROTECT && addr_arr[gnt_idx] == '0);
          reg_d  = addr_arr[gnt_idx];
          data_d = data_arr[gnt_idx];
          gid_d  = gnt_idx;
          ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
      end
      default: state_d = S_INIT;
    endcase
    busy_d = (state_d == S_INIT);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state         <= S_INIT;
      cnt           <= '0;
      ptr           <= '0;
      busy          <= 1'b1;
      grant_id      <= '0;
      rf_write      <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      ptr           <= ptr_d;
      busy          <= busy_d;
      grant_id      <= gid_d;
      rf_write      <= wr_d;
      rf_write_reg  <= reg_d;
      rf_write_data <= data_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a cycle-level model plus literal checks of the key scenarios.
module tb_regfile_write_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

`ifdef RF_ARB_R0_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic              clk;
  logic              clr;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              init_start;
  logic              busy;
  logic [1:0]        grant_id;
  logic              rf_write;
  logic [AW-1:0]     rf_write_reg;
  logic [DW-1:0]     rf_write_data;

  regfile_write_arbiter dut (
    .clk          (clk),
    .clr          (clr),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .init_start   (init_start),
    .busy         (busy),
    .grant_id     (grant_id),
    .rf_write     (rf_write),
    .rf_write_reg (rf_write_reg),
    .rf_write_data(rf_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: sweep position (-1 when running), rotating pointer, expected write-port values
  bit           model_ok = 1'b0;
  int           m_sweep;
  int           m_ptr;
  bit           e_write;
  int           e_reg;
  logic [31:0]  e_data;
  int           e_gid;

  function automatic int find_grant();
    int g;
    for (int o = 0; o < NREQ; o++) begin
      g = (m_ptr + o) % NREQ;
      if (req_valid[g]) return g;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    logic [NREQ-1:0] r;
    r = '0;
    if (m_sweep < 0 && !init_start) begin
      g = find_grant();
      if (g >= 0) r[g] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    int g;
    if (clr) begin
      model_ok = 1'b1;
      m_sweep  = 0;
      m_ptr    = 0;
      e_write  = 1'b0;
      e_reg    = 0;
      e_data   = '0;
      e_gid    = 0;
    end else if (model_ok) begin
      if (m_sweep >= 0) begin
        e_write = !(PROT && m_sweep == 0);
        e_reg   = m_sweep;
        e_data  = '0;
        m_sweep = (m_sweep == 31) ? -1 : m_sweep + 1;
      end else if (init_start) begin
        e_write = 1'b0;
        m_sweep = 0;
      end else begin
        g = find_grant();
        if (g >= 0) begin
          e_reg   = int'(req_addr[g*AW +: AW]);
          e_data  = req_data[g*DW +: DW];
          e_write = !(PROT && e_reg == 0);
          e_gid   = g;
          m_ptr   = (g + 1) % NREQ;
        end else begin
          e_write = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (model_ok) begin
      chk("cmp_busy", busy, (m_sweep >= 0));
      chk("cmp_write", rf_write, e_write);
      chk("cmp_gid", grant_id, e_gid);
      chk("cmp_ready", req_ready, exp_ready());
      if (e_write) begin
        chk("cmp_reg", rf_write_reg, e_reg);
        chk("cmp_data", rf_write_data, e_data);
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  int rr_exp[6];
  int n;

  initial begin
    rr_exp     = '{0, 1, 2, 0, 1, 2};
    clr        = 1'b1;
    init_start = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    req_data   = '0;

    // Reset and sweep
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("rst_write", rf_write, 0);
    chk("rst_reg", rf_write_reg, 0);
    chk("rst_data", rf_write_data, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", req_ready, 0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("sweep_write", rf_write, (PROT && k == 0) ? 0 : 1);
      chk("sweep_reg", rf_write_reg, k);
      chk("sweep_data", rf_write_data, 0);
      chk("sweep_busy", busy, (k < 31) ? 1 : 0);
    end

    // Round-robin with all three requesters
    @(posedge clk); #1;
    set_req(0, 1'b1, 5'd5, 32'hA);
    set_req(1, 1'b1, 5'd6, 32'hB);
    set_req(2, 1'b1, 5'd7, 32'hC);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rr_ready", req_ready, 3'b001 << rr_exp[c]);
      if (c > 0) begin
        chk("rr_write", rf_write, 1);
        chk("rr_reg", rf_write_reg, 5 + rr_exp[c-1]);
        chk("rr_data", rf_write_data, 10 + rr_exp[c-1]);
        chk("rr_gid", grant_id, rr_exp[c-1]);
      end
    end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("rr_last_reg", rf_write_reg, 7);
    chk("rr_last_gid", grant_id, 2);

    // Single requester 2, back-to-back, then pointer wrap check
    @(posedge clk); #1;
    set_req(2, 1'b1, 5'd31, 32'hDEADBEEF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("single_ready", req_ready, 3'b100);
      if (c > 0) begin
        chk("single_write", rf_write, 1);
        chk("single_reg", rf_write_reg, 31);
        chk("single_data", rf_write_data, 32'hDEADBEEF);
      end
    end
    @(posedge clk); #1;
    set_req(0, 1'b1, 5'd1, 32'h11);
    @(negedge clk);
    chk("single_last_data", rf_write_data, 32'hDEADBEEF);
    chk("ptr_wrap", req_ready, 3'b001);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("wrap_reg", rf_write_reg, 1);
    chk("wrap_gid", grant_id, 0);

    // init_start in RUN together with a request
    @(posedge clk); #1;
    set_req(0, 1'b1, 5'd3, 32'h55);
    init_start = 1'b1;
    @(negedge clk);
    chk("init_no_grant", req_ready, 0);
    @(posedge clk); #1 init_start = 1'b0;
    @(negedge clk);
    chk("init_idle_write", rf_write, 0);
    chk("init_busy", busy, 1);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("resweep_reg", rf_write_reg, k);
      chk("resweep_ready", req_ready, (k < 31) ? 3'b000 : 3'b001);
    end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("init_grant_write", rf_write, 1);
    chk("init_grant_reg", rf_write_reg, 3);
    chk("init_grant_data", rf_write_data, 32'h55);

    // clr in the middle of a sweep
    @(posedge clk); #1 init_start = 1'b1;
    @(posedge clk); #1 init_start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("mid_reg10", rf_write_reg, 10);
    clr = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("clr_no_write", rf_write, 0);
      chk("clr_busy", busy, 1);
    end
    clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("restart_reg", rf_write_reg, k);
    end
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_end_bound", busy, 0);

    // Write to register 0 from requester 1
    @(posedge clk); #1;
    set_req(1, 1'b1, 5'd0, 32'h1234);
    @(negedge clk);
    chk("r0_ready", req_ready, 3'b010);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk("r0_write", rf_write, PROT ? 0 : 1);
    chk("r0_gid", grant_id, 1);
`ifndef RF_ARB_R0_PROTECT_EN
    chk("r0_reg", rf_write_reg, 0);
    chk("r0_data", rf_write_data, 32'h1234);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
